// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: register address type, per-stage stall/flush structs, controller
// state enum and forwarding-select encodings.
package hazard_ctrl_pkg;

   localparam int CREG_W = 5;
   typedef logic [CREG_W-1:0] creg_addr_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      IWAIT = 2'd1,
      DWAIT = 2'd2,
      IKILL = 2'd3
   } hazard_state_t;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef struct packed {
      logic stall;
      logic flush;
   } hazard_data_item_t;

   typedef struct packed {
      hazard_data_item_t fetch;
      hazard_data_item_t decode;
      hazard_data_item_t execute;
      hazard_data_item_t memory;
   } hazard_data_t;

   // Every stage register loads a bubble, nothing holds.
   localparam hazard_data_t HAZ_RESET = '{
      fetch:   '{stall: 1'b0, flush: 1'b1},
      decode:  '{stall: 1'b0, flush: 1'b1},
      execute: '{stall: 1'b0, flush: 1'b1},
      memory:  '{stall: 1'b0, flush: 1'b1}
   };

endpackage

// File: rtl/hazard_ctrl_fwd_sel_unit.sv
// Per-operand forwarding select and decode-side dependency flags.
// Latency: purely combinational.
// Backpressure: none; results are consumed by the hazard controller.
// Ports: d_src_i/e_src_i operand addresses; e_/m_/w_ writer address+enable;
//        sel_o execute operand select; d_e_match_o/d_m_match_o decode operand
//        depends on the E/M writer.
module fwd_sel_unit
   import hazard_ctrl_pkg::*;
#(
   parameter int RW     = 5,
   parameter int FWD_EN = 1
) (
   input  logic [RW-1:0] d_src_i,
   input  logic [RW-1:0] e_src_i,
   input  logic [RW-1:0] e_write_reg_i,
   input  logic          e_reg_write_i,
   input  logic [RW-1:0] m_write_reg_i,
   input  logic          m_reg_write_i,
   input  logic [RW-1:0] w_write_reg_i,
   input  logic          w_reg_write_i,
   output logic [1:0]    sel_o,
   output logic          d_e_match_o,
   output logic          d_m_match_o
);

   logic e_src_m_hit;
   logic e_src_w_hit;

   // r0 is hardwired to zero, so it never creates a dependency.
   assign e_src_m_hit = m_reg_write_i && (e_src_i != '0) && (e_src_i == m_write_reg_i);
   assign e_src_w_hit = w_reg_write_i && (e_src_i != '0) && (e_src_i == w_write_reg_i);
   assign d_e_match_o = e_reg_write_i && (d_src_i != '0) && (d_src_i == e_write_reg_i);
   assign d_m_match_o = m_reg_write_i && (d_src_i != '0) && (d_src_i == m_write_reg_i);

   always_comb begin
      sel_o = FWD_RF;
      if (FWD_EN != 0) begin
         // M holds the younger result, so it beats W.
         if (e_src_m_hit) begin
            sel_o = FWD_M;
         end else if (e_src_w_hit) begin
            sel_o = FWD_W;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush/forwarding controller for the 5-stage pipeline.
// Latency: hazard/fwd_sel combinational from state and inputs; counters update at the edge.
// Backpressure: imem/dmem req-without-ack holds the affected stages until ack.
// Ports: d_src/e_src operand addresses (operand i at [i*RW +: RW]); E/M/W writer
//        info; m_branch_taken redirect; imem/dmem req/ack; hazard per-stage
//        stall/flush; fwd_sel 2 bits per execute operand; saturating counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int NSRC   = 2,
   parameter int RW     = 5,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NSRC*RW-1:0]   d_src,
   input  logic [NSRC*RW-1:0]   e_src,
   input  logic [RW-1:0]        e_write_reg,
   input  logic                 e_reg_write,
   input  logic                 e_mem_to_reg,
   input  logic [RW-1:0]        m_write_reg,
   input  logic                 m_reg_write,
   input  logic [RW-1:0]        w_write_reg,
   input  logic                 w_reg_write,
   input  logic                 m_branch_taken,
   input  logic                 imem_req,
   input  logic                 imem_ack,
   input  logic                 dmem_req,
   input  logic                 dmem_ack,
   output hazard_data_t         hazard,
   output logic [2*NSRC-1:0]    fwd_sel,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   logic [NSRC-1:0]   d_e_match;
   logic [NSRC-1:0]   d_m_match;
   logic [2*NSRC-1:0] fwd_raw;

   for (genvar gi = 0; gi < NSRC; gi++) begin : g_fwd
      fwd_sel_unit #(
         .RW     (RW),
         .FWD_EN (FWD_EN)
      ) u_fwd (
         .d_src_i       (d_src[gi*RW +: RW]),
         .e_src_i       (e_src[gi*RW +: RW]),
         .e_write_reg_i (e_write_reg),
         .e_reg_write_i (e_reg_write),
         .m_write_reg_i (m_write_reg),
         .m_reg_write_i (m_reg_write),
         .w_write_reg_i (w_write_reg),
         .w_reg_write_i (w_reg_write),
         .sel_o         (fwd_raw[2*gi +: 2]),
         .d_e_match_o   (d_e_match[gi]),
         .d_m_match_o   (d_m_match[gi])
      );
   end

   hazard_state_t    state_q, state_d;
   logic             kill_pending_q, kill_pending_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic         dwait;
   logic         imem_wait;
   logic         kill_active;
   logic         load_use;
   logic         raw_stall;
   logic         branch_fire;
   logic         stall_any;
   hazard_data_t haz;

   assign dwait       = dmem_req & ~dmem_ack;
   assign imem_wait   = imem_req & ~imem_ack;
   // A wrong-path fetch is still in flight, either visibly (IKILL) or parked
   // behind a data-memory wait.
   assign kill_active = (state_q == IKILL) | kill_pending_q;
   assign load_use    = e_mem_to_reg & (|d_e_match);
   // Without forwarding, any E/M producer blocks decode; W is safe because
   // the register file writes before it is read within the cycle.
   assign raw_stall   = (FWD_EN == 0) && (|(d_e_match | d_m_match));
   // A branch frozen in M by a dmem wait is only acted on once M moves.
   assign branch_fire = ~dwait & m_branch_taken;

   always_comb begin
      haz            = '0;
      state_d        = RUN;
      kill_pending_d = 1'b0;
      if (dwait) begin
         haz.fetch.stall   = 1'b1;
         haz.decode.stall  = 1'b1;
         haz.execute.stall = 1'b1;
         haz.memory.stall  = 1'b1;
         haz.memory.flush  = 1'b1;
         // IF/ID holds a bubble while a kill is parked; keep discarding.
         haz.fetch.flush   = kill_active;
         state_d           = DWAIT;
         kill_pending_d    = kill_active & ~imem_ack;
      end else if (m_branch_taken) begin
         haz.fetch.flush   = 1'b1;
         haz.decode.flush  = 1'b1;
         haz.execute.flush = 1'b1;
         state_d           = imem_wait ? IKILL : RUN;
      end else begin
         if (load_use || raw_stall) begin
            haz.fetch.stall   = 1'b1;
            haz.decode.stall  = 1'b1;
            haz.execute.flush = 1'b1;
         end else if (imem_wait) begin
            haz.fetch.stall = 1'b1;
            haz.fetch.flush = 1'b1;
         end
         if (kill_active) begin
            // Discard through and including the ack cycle.
            haz.fetch.stall = 1'b1;
            haz.fetch.flush = 1'b1;
            state_d         = imem_ack ? RUN : IKILL;
         end else if (imem_wait) begin
            state_d = IWAIT;
         end
      end
   end

   assign stall_any = haz.fetch.stall | haz.decode.stall |
                      haz.execute.stall | haz.memory.stall;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_any && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (branch_fire && !(&flush_cnt_q)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= RUN;
         kill_pending_q <= 1'b0;
         stall_cnt_q    <= '0;
         flush_cnt_q    <= '0;
      end else begin
         state_q        <= state_d;
         kill_pending_q <= kill_pending_d;
         stall_cnt_q    <= stall_cnt_d;
         flush_cnt_q    <= flush_cnt_d;
      end
   end

   assign hazard    = reset ? HAZ_RESET : haz;
   assign fwd_sel   = reset ? '0 : fwd_raw;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: one forwarding instance (32-bit counters) and one
// no-forwarding instance (4-bit counters) share the same stimulus.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   logic        clk;
   logic        reset;
   logic [9:0]  d_src, e_src;
   logic [4:0]  e_write_reg, m_write_reg, w_write_reg;
   logic        e_reg_write, e_mem_to_reg, m_reg_write, w_reg_write;
   logic        m_branch_taken, imem_req, imem_ack, dmem_req, dmem_ack;

   hazard_data_t haz0, haz1;
   logic [3:0]   fwd0, fwd1;
   logic [31:0]  sc0, fc0;
   logic [3:0]   sc1, fc1;

   hazard_ctrl #(.NSRC(2), .RW(5), .FWD_EN(1), .CNT_W(32)) dut0 (
      .clk(clk), .reset(reset), .d_src(d_src), .e_src(e_src),
      .e_write_reg(e_write_reg), .e_reg_write(e_reg_write), .e_mem_to_reg(e_mem_to_reg),
      .m_write_reg(m_write_reg), .m_reg_write(m_reg_write),
      .w_write_reg(w_write_reg), .w_reg_write(w_reg_write),
      .m_branch_taken(m_branch_taken), .imem_req(imem_req), .imem_ack(imem_ack),
      .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .hazard(haz0), .fwd_sel(fwd0), .stall_cnt(sc0), .flush_cnt(fc0));

   hazard_ctrl #(.NSRC(2), .RW(5), .FWD_EN(0), .CNT_W(4)) dut1 (
      .clk(clk), .reset(reset), .d_src(d_src), .e_src(e_src),
      .e_write_reg(e_write_reg), .e_reg_write(e_reg_write), .e_mem_to_reg(e_mem_to_reg),
      .m_write_reg(m_write_reg), .m_reg_write(m_reg_write),
      .w_write_reg(w_write_reg), .w_reg_write(w_reg_write),
      .m_branch_taken(m_branch_taken), .imem_req(imem_req), .imem_ack(imem_ack),
      .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .hazard(haz1), .fwd_sel(fwd1), .stall_cnt(sc1), .flush_cnt(fc1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;

   // Reference model state: a wrong-path instruction still owed by imem,
   // and the expected counter values of each instance.
   bit     m_kill;
   longint m_sc0, m_fc0, m_sc1, m_fc1;

   localparam logic [7:0] H_RESET  = 8'b01_01_01_01;
   localparam logic [7:0] H_NONE   = 8'b00_00_00_00;
   localparam logic [7:0] H_BUBBLE = 8'b10_10_01_00;
   localparam logic [7:0] H_BRANCH = 8'b01_01_01_00;
   localparam logic [7:0] H_IHOLD  = 8'b11_00_00_00;
   localparam logic [7:0] H_DHOLD  = 8'b10_10_10_11;

   function automatic bit hits(input logic [4:0] a, input logic [4:0] w, input logic we);
      return we && (a != 5'd0) && (a == w);
   endfunction

   // First applicable prioritised rule: 1 dmem wait, 2 branch, 3 load-use,
   // 4 no-forward RAW, 5 imem wait, 0 nothing.
   function automatic int active_rule(input bit fwd_en);
      bit lu = 0, nf = 0;
      for (int i = 0; i < 2; i++) begin
         logic [4:0] a;
         a = d_src[i*5 +: 5];
         if (e_mem_to_reg && hits(a, e_write_reg, e_reg_write)) lu = 1;
         if (!fwd_en && (hits(a, e_write_reg, e_reg_write) || hits(a, m_write_reg, m_reg_write))) nf = 1;
      end
      if (dmem_req && !dmem_ack) return 1;
      if (m_branch_taken) return 2;
      if (lu) return 3;
      if (nf) return 4;
      if (imem_req && !imem_ack) return 5;
      return 0;
   endfunction

   function automatic hazard_data_t exp_haz(input bit fwd_en, input bit kill);
      hazard_data_t h;
      int r;
      if (reset) begin
         h = H_RESET;
         return h;
      end
      r = active_rule(fwd_en);
      case (r)
         1:       h = H_DHOLD;
         2:       h = H_BRANCH;
         3, 4:    h = H_BUBBLE;
         5:       h = H_IHOLD;
         default: h = H_NONE;
      endcase
      if (kill && r == 1) h.fetch.flush = 1'b1;
      if (kill && r != 1 && r != 2) begin
         h.fetch.stall = 1'b1;
         h.fetch.flush = 1'b1;
      end
      return h;
   endfunction

   function automatic logic [3:0] exp_fwd(input bit fwd_en);
      logic [3:0] res;
      res = 4'b0000;
      if (reset || !fwd_en) return res;
      for (int i = 0; i < 2; i++) begin
         logic [4:0] a;
         a = e_src[i*5 +: 5];
         if (hits(a, m_write_reg, m_reg_write))      res[i*2 +: 2] = 2'b10;
         else if (hits(a, w_write_reg, w_reg_write)) res[i*2 +: 2] = 2'b01;
      end
      return res;
   endfunction

   function automatic longint sat_inc(input longint v, input longint maxv);
      return (v >= maxv) ? maxv : v + 1;
   endfunction

   function automatic bit stalls(input hazard_data_t h);
      return h.fetch.stall || h.decode.stall || h.execute.stall || h.memory.stall;
   endfunction

   task automatic set_reset(input bit v);
      reset = v;
      if (v) begin
         m_kill = 0; m_sc0 = 0; m_fc0 = 0; m_sc1 = 0; m_fc1 = 0;
      end
   endtask

   // Advance the model over the coming edge, then move to the next negedge.
   task automatic tick();
      hazard_data_t h0, h1;
      int r;
      h0 = exp_haz(1, m_kill);
      h1 = exp_haz(0, m_kill);
      r  = active_rule(1);
      if (!reset) begin
         if (stalls(h0)) m_sc0 = sat_inc(m_sc0, 64'hFFFF_FFFF);
         if (stalls(h1)) m_sc1 = sat_inc(m_sc1, 15);
         if (r == 2) begin
            m_fc0 = sat_inc(m_fc0, 64'hFFFF_FFFF);
            m_fc1 = sat_inc(m_fc1, 15);
         end
         if (r == 1)      m_kill = m_kill && !imem_ack;
         else if (r == 2) m_kill = imem_req && !imem_ack;
         else             m_kill = m_kill && !imem_ack;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      d_src = '0; e_src = '0;
      e_write_reg = '0; m_write_reg = '0; w_write_reg = '0;
      e_reg_write = 0; e_mem_to_reg = 0; m_reg_write = 0; w_reg_write = 0;
      m_branch_taken = 0; imem_req = 0; imem_ack = 0; dmem_req = 0; dmem_ack = 0;
   endtask

   task automatic do_reset();
      idle();
      set_reset(1);
      tick();
      set_reset(0);
   endtask

   task automatic test_reset();
      #1;
      checks++; if (haz0 !== H_RESET) begin errors++; $display("FAIL reset_haz0: got %b expected %b", haz0, H_RESET); end
      checks++; if (haz1 !== H_RESET) begin errors++; $display("FAIL reset_haz1: got %b expected %b", haz1, H_RESET); end
      checks++; if (fwd0 !== 4'b0) begin errors++; $display("FAIL reset_fwd: got %b expected 0000", fwd0); end
      checks++; if (sc0 !== 32'd0 || fc0 !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", sc0, fc0); end
      tick();
      set_reset(0);
      #1;
      checks++; if (haz0 !== H_NONE) begin errors++; $display("FAIL reset_release: got %b expected %b", haz0, H_NONE); end
      tick();
   endtask

   task automatic test_forwarding();
      idle();
      e_src = {5'd0, 5'd3};
      m_write_reg = 5'd3; m_reg_write = 1; w_write_reg = 5'd3; w_reg_write = 1;
      #1;
      checks++; if (fwd0 !== 4'b0010) begin errors++; $display("FAIL fwd_m_prio: got %b expected 0010", fwd0); end
      checks++; if (fwd1 !== 4'b0000) begin errors++; $display("FAIL fwd_nofwd: got %b expected 0000", fwd1); end
      m_reg_write = 0;
      #1;
      checks++; if (fwd0 !== 4'b0001) begin errors++; $display("FAIL fwd_w: got %b expected 0001", fwd0); end
      e_src = {5'd3, 5'd0};
      #1;
      checks++; if (fwd0 !== 4'b0100) begin errors++; $display("FAIL fwd_op1_w: got %b expected 0100", fwd0); end
      e_src = '0; m_write_reg = 0; m_reg_write = 1; w_write_reg = 0;
      #1;
      checks++; if (fwd0 !== 4'b0000) begin errors++; $display("FAIL fwd_r0: got %b expected 0000", fwd0); end
      tick();
      idle();
   endtask

   task automatic test_load_use();
      do_reset();
      e_mem_to_reg = 1; e_reg_write = 1; e_write_reg = 5'd8; d_src = {5'd8, 5'd0};
      #1;
      checks++; if (haz0 !== H_BUBBLE) begin errors++; $display("FAIL lu_bubble: got %b expected %b", haz0, H_BUBBLE); end
      tick();
      e_mem_to_reg = 0; e_reg_write = 0; e_write_reg = 0; m_write_reg = 5'd8; m_reg_write = 1;
      #1;
      checks++; if (haz0 !== H_NONE) begin errors++; $display("FAIL lu_once: got %b expected %b", haz0, H_NONE); end
      tick();
      d_src = '0; e_src = {5'd8, 5'd0}; m_reg_write = 0; m_write_reg = 0;
      w_write_reg = 5'd8; w_reg_write = 1;
      #1;
      checks++; if (fwd0 !== 4'b0100) begin errors++; $display("FAIL lu_fwd_w: got %b expected 0100", fwd0); end
      checks++; if (sc0 !== 32'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", sc0); end
      tick();
      idle();
   endtask

   task automatic test_branch_imem();
      do_reset();
      imem_req = 1; imem_ack = 0; m_branch_taken = 1;
      #1;
      checks++; if (haz0 !== H_BRANCH) begin errors++; $display("FAIL br_flush: got %b expected %b", haz0, H_BRANCH); end
      tick();
      m_branch_taken = 0;
      for (int c = 0; c < 3; c++) begin
         if (c == 2) imem_ack = 1;
         #1;
         checks++; if (haz0 !== H_IHOLD) begin errors++; $display("FAIL br_ikill_%0d: got %b expected %b", c, haz0, H_IHOLD); end
         tick();
      end
      imem_req = 1; imem_ack = 1;
      #1;
      checks++; if (haz0 !== H_NONE) begin errors++; $display("FAIL br_run: got %b expected %b", haz0, H_NONE); end
      checks++; if (fc0 !== 32'd1) begin errors++; $display("FAIL br_flush_cnt: got %0d expected 1", fc0); end
      tick();
      idle();
   endtask

   task automatic test_dmem_branch();
      do_reset();
      dmem_req = 1; dmem_ack = 0; m_branch_taken = 1;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++; if (haz0 !== H_DHOLD) begin errors++; $display("FAIL dw_hold_%0d: got %b expected %b", c, haz0, H_DHOLD); end
         tick();
      end
      dmem_ack = 1;
      #1;
      checks++; if (haz0 !== H_BRANCH) begin errors++; $display("FAIL dw_branch: got %b expected %b", haz0, H_BRANCH); end
      tick();
      idle();
      #1;
      checks++; if (sc0 !== 32'd4) begin errors++; $display("FAIL dw_stall_cnt: got %0d expected 4", sc0); end
      checks++; if (fc0 !== 32'd1) begin errors++; $display("FAIL dw_flush_cnt: got %0d expected 1", fc0); end
      tick();
   endtask

   task automatic test_nofwd();
      do_reset();
      d_src = {5'd0, 5'd5}; e_src = {5'd0, 5'd5}; m_write_reg = 5'd5; m_reg_write = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (haz1 !== H_BUBBLE) begin errors++; $display("FAIL nf_stall_%0d: got %b expected %b", c, haz1, H_BUBBLE); end
         checks++; if (fwd1 !== 4'b0000) begin errors++; $display("FAIL nf_fwd_%0d: got %b expected 0000", c, fwd1); end
         tick();
      end
      #1;
      checks++; if (haz0 !== H_NONE) begin errors++; $display("FAIL nf_fwd_inst: got %b expected %b", haz0, H_NONE); end
      m_reg_write = 0; w_write_reg = 5'd5; w_reg_write = 1;
      #1;
      checks++; if (haz1 !== H_NONE) begin errors++; $display("FAIL nf_clear: got %b expected %b", haz1, H_NONE); end
      checks++; if (fwd0 !== 4'b0001) begin errors++; $display("FAIL nf_fwd0_w: got %b expected 0001", fwd0); end
      e_write_reg = 5'd5; e_reg_write = 1;
      #1;
      checks++; if (haz1 !== H_BUBBLE) begin errors++; $display("FAIL nf_e_writer: got %b expected %b", haz1, H_BUBBLE); end
      tick();
      idle();
   endtask

   task automatic test_async_reset();
      hazard_data_t e;
      do_reset();
      m_branch_taken = 1; imem_req = 1; imem_ack = 0;
      tick();
      m_branch_taken = 0; dmem_req = 1; dmem_ack = 0;
      e = H_DHOLD; e.fetch.flush = 1'b1;
      #1;
      checks++; if (haz0 !== e) begin errors++; $display("FAIL ar_kill_park: got %b expected %b", haz0, e); end
      tick();
      #3;
      set_reset(1);
      #1;
      checks++; if (haz0 !== H_RESET) begin errors++; $display("FAIL ar_haz0: got %b expected %b", haz0, H_RESET); end
      checks++; if (haz1 !== H_RESET) begin errors++; $display("FAIL ar_haz1: got %b expected %b", haz1, H_RESET); end
      checks++; if (sc0 !== 32'd0) begin errors++; $display("FAIL ar_cnt_clear: got %0d expected 0", sc0); end
      tick();
      idle();
      set_reset(0);
      #1;
      checks++; if (haz0 !== H_NONE) begin errors++; $display("FAIL ar_no_kill: got %b expected %b", haz0, H_NONE); end
      checks++; if (sc0 !== 32'd0 || fc0 !== 32'd0) begin errors++; $display("FAIL ar_cnt: got %0d/%0d expected 0/0", sc0, fc0); end
      tick();
   endtask

   task automatic test_saturation();
      do_reset();
      dmem_req = 1; dmem_ack = 0;
      for (int c = 0; c < 20; c++) tick();
      idle();
      #1;
      checks++; if (sc1 !== 4'hF) begin errors++; $display("FAIL sat_stall: got %0d expected 15", sc1); end
      checks++; if (sc0 !== 32'd20) begin errors++; $display("FAIL sat_stall_wide: got %0d expected 20", sc0); end
      m_branch_taken = 1;
      for (int c = 0; c < 18; c++) tick();
      idle();
      #1;
      checks++; if (fc1 !== 4'hF) begin errors++; $display("FAIL sat_flush: got %0d expected 15", fc1); end
      checks++; if (fc0 !== 32'd18) begin errors++; $display("FAIL sat_flush_wide: got %0d expected 18", fc0); end
      checks++; if (sc1 !== 4'hF) begin errors++; $display("FAIL sat_hold: got %0d expected 15", sc1); end
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 600; n++) begin
         hazard_data_t e0, e1;
         d_src = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         e_src = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         e_write_reg = 5'($urandom_range(0, 3));
         m_write_reg = 5'($urandom_range(0, 3));
         w_write_reg = 5'($urandom_range(0, 3));
         e_reg_write = 1'($urandom_range(0, 1));
         m_reg_write = 1'($urandom_range(0, 1));
         w_reg_write = 1'($urandom_range(0, 1));
         e_mem_to_reg = ($urandom_range(0, 3) == 0);
         m_branch_taken = ($urandom_range(0, 7) == 0);
         imem_req = 1'($urandom_range(0, 1));
         imem_ack = imem_req && ($urandom_range(0, 2) == 0);
         dmem_req = ($urandom_range(0, 3) == 0);
         dmem_ack = dmem_req && ($urandom_range(0, 1) == 1);
         set_reset($urandom_range(0, 99) == 0);
         #1;
         e0 = exp_haz(1, m_kill);
         e1 = exp_haz(0, m_kill);
         checks++; if (haz0 !== e0) begin errors++; $display("FAIL rnd_haz0 @%0d: got %b expected %b", n, haz0, e0); end
         checks++; if (haz1 !== e1) begin errors++; $display("FAIL rnd_haz1 @%0d: got %b expected %b", n, haz1, e1); end
         checks++; if (fwd0 !== exp_fwd(1)) begin errors++; $display("FAIL rnd_fwd0 @%0d: got %b expected %b", n, fwd0, exp_fwd(1)); end
         checks++; if (fwd1 !== exp_fwd(0)) begin errors++; $display("FAIL rnd_fwd1 @%0d: got %b expected %b", n, fwd1, exp_fwd(0)); end
         checks++; if (sc0 !== 32'(m_sc0) || fc0 !== 32'(m_fc0)) begin errors++; $display("FAIL rnd_cnt0 @%0d: got %0d/%0d expected %0d/%0d", n, sc0, fc0, m_sc0, m_fc0); end
         checks++; if (sc1 !== 4'(m_sc1) || fc1 !== 4'(m_fc1)) begin errors++; $display("FAIL rnd_cnt1 @%0d: got %0d/%0d expected %0d/%0d", n, sc1, fc1, m_sc1, m_fc1); end
         tick();
      end
      set_reset(0);
      idle();
   endtask

   initial begin
      idle();
      set_reset(1);
      @(negedge clk);
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch_imem();
      test_dmem_branch();
      test_nofwd();
      test_async_reset();
      test_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
